mc_control_unit: RTL

Multicycle control unit for the 32-bit datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states, driving datapath mux selects, register and memory enables, and the 3-bit `alu_control` consumed by the ALU. It consumes the ALU `zero_flag` for branch resolution and stalls on a memory-ready handshake.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_control_unit_if.sv | 38 +++
 rtl/alu_decoder.sv | 25 ++
 rtl/mc_control_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, ISA field
// constants, ALU operation codes and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_ZERO = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_NOR  = 3'b111;

  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_out_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and status in, control strobes out.
interface mc_control_unit_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
           alu_src_b, alu_control, pc_src, reg_write, reg_dst, mem_to_reg,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
           alu_src_b, alu_control, pc_src, reg_write, reg_dst, mem_to_reg,
           instr_done, illegal_op
  );

endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation mapping; valid_o flags a supported funct.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       valid_o
);

  always_comb begin
    alu_control_o = ALU_ZERO;
    valid_o       = 1'b1;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_SLT:  alu_control_o = ALU_SLT;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_XOR:  alu_control_o = ALU_XOR;
      FN_NOR:  alu_control_o = ALU_NOR;
      default: valid_o       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: one registered state, outputs decoded from it (plus
// mem_ready / zero_flag in the states that consume them).
module mc_control_unit
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_control_unit_if.master  ctrl_if
);

  state_e     state_q, state_d;
  ctrl_out_t  outs;
  logic [2:0] fn_alu;
  logic       fn_valid;

  alu_decoder u_alu_decoder (
    .funct_i       (ctrl_if.funct),
    .alu_control_o (fn_alu),
    .valid_o       (fn_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    outs    = '0;
    state_d = S_FETCH;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        outs.mem_read    = 1'b1;
        outs.alu_src_b   = ALUB_FOUR;
        outs.alu_control = ALU_ADD;
        outs.pc_src      = PCSRC_ALU;
        outs.ir_write    = ctrl_if.mem_ready;
        outs.pc_write    = ctrl_if.mem_ready;
        state_d          = ctrl_if.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here regardless of the opcode.
        outs.alu_src_b   = ALUB_IMM_SH2;
        outs.alu_control = ALU_ADD;
        if (is_mem_op(ctrl_if.opcode)) begin
          state_d = S_MEM_ADDR;
        end else begin
          case (ctrl_if.opcode)
            OP_RTYPE: begin
              if (fn_valid) state_d = S_R_EXEC;
              else          outs.illegal_op = 1'b1;
            end
            OP_BEQ:  state_d = S_BRANCH;
            OP_ADDI: state_d = S_ADDI_EXEC;
            OP_J:    state_d = S_JUMP;
            default: outs.illegal_op = 1'b1;
          endcase
        end
      end
      S_MEM_ADDR: begin
        outs.alu_src_a   = 1'b1;
        outs.alu_src_b   = ALUB_IMM;
        outs.alu_control = ALU_ADD;
        state_d          = (ctrl_if.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        outs.mem_read = 1'b1;
        outs.i_or_d   = 1'b1;
        state_d       = ctrl_if.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        outs.reg_write  = 1'b1;
        outs.mem_to_reg = 1'b1;
        outs.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        outs.mem_write  = 1'b1;
        outs.i_or_d     = 1'b1;
        outs.instr_done = ctrl_if.mem_ready;
        state_d         = ctrl_if.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        outs.alu_src_a   = 1'b1;
        outs.alu_src_b   = ALUB_REGB;
        outs.alu_control = fn_alu;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        outs.reg_write  = 1'b1;
        outs.reg_dst    = 1'b1;
        outs.instr_done = 1'b1;
      end
      S_BRANCH: begin
        outs.alu_src_a   = 1'b1;
        outs.alu_src_b   = ALUB_REGB;
        outs.alu_control = ALU_SUB;
        outs.pc_src      = PCSRC_ALUOUT;
        outs.pc_write    = ctrl_if.zero_flag;
        outs.instr_done  = 1'b1;
      end
      S_ADDI_EXEC: begin
        outs.alu_src_a   = 1'b1;
        outs.alu_src_b   = ALUB_IMM;
        outs.alu_control = ALU_ADD;
        state_d          = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        outs.reg_write  = 1'b1;
        outs.instr_done = 1'b1;
      end
      S_JUMP: begin
        outs.pc_src     = PCSRC_JUMP;
        outs.pc_write   = 1'b1;
        outs.instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctrl_if.pc_write    = outs.pc_write;
  assign ctrl_if.ir_write    = outs.ir_write;
  assign ctrl_if.mem_read    = outs.mem_read;
  assign ctrl_if.mem_write   = outs.mem_write;
  assign ctrl_if.i_or_d      = outs.i_or_d;
  assign ctrl_if.alu_src_a   = outs.alu_src_a;
  assign ctrl_if.alu_src_b   = outs.alu_src_b;
  assign ctrl_if.alu_control = outs.alu_control;
  assign ctrl_if.pc_src      = outs.pc_src;
  assign ctrl_if.reg_write   = outs.reg_write;
  assign ctrl_if.reg_dst     = outs.reg_dst;
  assign ctrl_if.mem_to_reg  = outs.mem_to_reg;
  assign ctrl_if.instr_done  = outs.instr_done;
  assign ctrl_if.illegal_op  = outs.illegal_op;

endmodule
